// File: rtl/uart_cmd_pkg.sv
// Shared types and field positions for the UART command parser.
// Holds the FSM state enum, opcode layout, default sync byte and error flag indices.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_OPC   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_ISSUE = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int OPC_WE_BIT  = 7;
  localparam int OPC_RSV_HI  = 6;
  localparam int OPC_RSV_LO  = 5;
  localparam int OPC_ADDR_HI = 4;
  localparam int OPC_ADDR_LO = 0;

  localparam int ERR_OPCODE  = 0;
  localparam int ERR_CSUM    = 1;
  localparam int ERR_TIMEOUT = 2;

  function automatic logic opc_ok(input logic [7:0] opc);
    return opc[OPC_RSV_HI:OPC_RSV_LO] == 2'b00;
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: restarts on clr, counts while en, and flags
// expire in the cycle whose edge would bring the count to CYCLES-1.
module uart_cmd_timer #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  // An accepted byte in the same cycle always wins over expiry.
  assign expire = en && !clr && (cnt == CW'(CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr || expire || !en) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: SYNC, OPC, optional 4 data bytes, XOR checksum,
// then presents one SRAM command with valid/ready handshake.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_we,
  output logic [4:0]  cmd_addr,
  output logic [31:0] cmd_wdata,
  output logic [2:0]  err_pulse
);

  state_t      state, state_d;
  logic        rdy_q;
  logic        accept;
  logic        expire;
  logic        tmr_en;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [2:0]  err_d;

  // rdy_q holds rx_ready low through reset and for the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign rx_ready  = rdy_q && (state != ST_ISSUE);
  assign cmd_valid = (state == ST_ISSUE);
  assign accept    = rx_valid && rx_ready;
  assign tmr_en    = (state == ST_OPC) || (state == ST_DATA) || (state == ST_CSUM);

  uart_cmd_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (tmr_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      err_pulse <= '0;
    end else begin
      state     <= state_d;
      err_pulse <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    err_d   = '0;
    unique case (state)
      ST_HUNT: begin
        if (accept && rx_data == SYNC_BYTE) state_d = ST_OPC;
      end
      ST_OPC: begin
        if (expire) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_HUNT;
        end else if (accept) begin
          if (!opc_ok(rx_data)) begin
            err_d[ERR_OPCODE] = 1'b1;
            state_d           = ST_HUNT;
          end else if (rx_data[OPC_WE_BIT]) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_HUNT;
        end else if (accept && byte_cnt == 2'd3) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (expire) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          state_d            = ST_HUNT;
        end else if (accept) begin
          if (rx_data == csum) begin
            state_d = ST_ISSUE;
          end else begin
            err_d[ERR_CSUM] = 1'b1;
            state_d         = ST_HUNT;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Command fields are rebuilt from scratch on every sync byte, so a frame
  // abandoned by error or timeout leaves nothing behind for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      csum      <= '0;
      byte_cnt  <= '0;
    end else if (accept) begin
      unique case (state)
        ST_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            csum      <= '0;
            byte_cnt  <= '0;
          end
        end
        ST_OPC: begin
          cmd_we   <= rx_data[OPC_WE_BIT];
          cmd_addr <= rx_data[OPC_ADDR_HI:OPC_ADDR_LO];
          csum     <= rx_data;
        end
        ST_DATA: begin
          cmd_wdata <= {cmd_wdata[23:0], rx_data};
          csum      <= csum ^ rx_data;
          byte_cnt  <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames go in byte by byte, expected
// commands are queued when a frame is sent and popped when cmd_valid appears.
module tb_uart_cmd_parser;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  err_pulse;

  int   vectors     = 0;
  int   miscompares = 0;
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .err_pulse (err_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and waits (bounded) for the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (rx_ready) done = 1;
      tick();
    end
    rx_valid = 1'b0;
    if (!done) chk("rx_ready_wait", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic check_cmd(input string tag);
    cmd_t e;
    chk({tag, "_valid"}, {31'd0, cmd_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_we"},    {31'd0, cmd_we},  {31'd0, e.we});
      chk({tag, "_addr"},  {27'd0, cmd_addr}, {27'd0, e.addr});
      chk({tag, "_wdata"}, cmd_wdata,         e.wdata);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_we",        {31'd0, cmd_we},    32'd0);
    chk("rst_addr",      {27'd0, cmd_addr},  32'd0);
    chk("rst_wdata",     cmd_wdata,          32'd0);
    chk("rst_err",       {29'd0, err_pulse}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", {31'd0, rx_ready}, 32'd0);
    tick();
    chk("rdy_after_edge",  {31'd0, rx_ready}, 32'd1);

    // Write, held across 3 cycles of cmd_ready=0
    exp_q.push_back('{we: 1'b1, addr: 5'd3, wdata: 32'hDEADBEEF});
    send_frame('{8'hA5, 8'h83, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA1});
    check_cmd("wr");
    chk("wr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_hold_valid", {31'd0, cmd_valid}, 32'd1);
      chk("wr_hold_wdata", cmd_wdata, 32'hDEADBEEF);
      chk("wr_hold_addr",  {27'd0, cmd_addr}, 32'd3);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("wr_release_valid", {31'd0, cmd_valid}, 32'd0);
    chk("wr_release_rdy",   {31'd0, rx_ready},  32'd1);

    // Read
    exp_q.push_back('{we: 1'b0, addr: 5'd31, wdata: 32'h0});
    send_frame('{8'hA5, 8'h1F, 8'h1F});
    check_cmd("rd");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("rd_release_valid", {31'd0, cmd_valid}, 32'd0);

    // Bad checksum, then a good read
    send_frame('{8'hA5, 8'h83, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA0});
    chk("csum_err",       {29'd0, err_pulse}, 32'b010);
    chk("csum_no_valid",  {31'd0, cmd_valid}, 32'd0);
    tick();
    chk("csum_err_clear", {29'd0, err_pulse}, 32'b000);
    exp_q.push_back('{we: 1'b0, addr: 5'd31, wdata: 32'h0});
    send_frame('{8'hA5, 8'h1F, 8'h1F});
    check_cmd("rd2");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // Bad opcode, then noise in HUNT
    send_frame('{8'hA5, 8'h41});
    chk("opc_err",       {29'd0, err_pulse}, 32'b001);
    tick();
    chk("opc_err_clear", {29'd0, err_pulse}, 32'b000);
    send_frame('{8'h00, 8'hFF, 8'h12});
    chk("noise_err",   {29'd0, err_pulse}, 32'b000);
    chk("noise_valid", {31'd0, cmd_valid}, 32'd0);
    tick();
    chk("noise_err2",  {29'd0, err_pulse}, 32'b000);

    // Sync byte value inside the frame is data
    exp_q.push_back('{we: 1'b1, addr: 5'd0, wdata: 32'hA5000000});
    send_frame('{8'hA5, 8'h80, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h25});
    check_cmd("syncdata");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // Timeout: 15 cycles after DE is accepted
    send_frame('{8'hA5, 8'h83, 8'hDE});
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_early", {29'd0, err_pulse}, 32'b000);
    tick();
    chk("tmo_fire",  {29'd0, err_pulse}, 32'b100);
    tick();
    chk("tmo_clear", {29'd0, err_pulse}, 32'b000);
    exp_q.push_back('{we: 1'b0, addr: 5'd31, wdata: 32'h0});
    send_frame('{8'hA5, 8'h1F, 8'h1F});
    check_cmd("rd3");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // Reset in the middle of DATA
    send_frame('{8'hA5, 8'h83, 8'hDE, 8'hAD});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy",   {31'd0, rx_ready},  32'd0);
    chk("mid_rst_we",    {31'd0, cmd_we},    32'd0);
    chk("mid_rst_addr",  {27'd0, cmd_addr},  32'd0);
    chk("mid_rst_wdata", cmd_wdata,          32'd0);
    chk("mid_rst_err",   {29'd0, err_pulse}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_err", {29'd0, err_pulse}, 32'd0);
    end
    exp_q.push_back('{we: 1'b1, addr: 5'd5, wdata: 32'h11223344});
    send_frame('{8'hA5, 8'h85, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC1});
    check_cmd("wr2");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("wr2_release", {31'd0, cmd_valid}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles between bytes inside a frame (minimum 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-006 SHALL have port rx_valid  input  1  rx_data valid this cycle.
REQ-007 SHALL have port rx_ready  output  1  parser accepts a byte this cycle.
REQ-008 SHALL have port cmd_valid  output  1  complete command presented.
REQ-009 SHALL have port cmd_ready  input  1  downstream SRAM controller takes the command.
REQ-010 SHALL have port cmd_we  output  1  1=write, 0=read.
REQ-011 SHALL have port cmd_addr  output  5  SRAM word address.
REQ-012 SHALL have port cmd_wdata  output  32  write data; 0 for reads.
REQ-013 SHALL have port err_pulse  output  3  one-cycle flags {timeout, checksum, opcode}.

Function
REQ-014 A byte SHALL be consumed only in a cycle where rx_valid and rx_ready are both 1.
REQ-015 Frame format SHALL be: SYNC_BYTE, OPC, [D3 D2 D1 D0 if write, MSB first], CSUM.
REQ-016 OPC SHALL be: bit7 = we, bits6:5 = 2'b00 (reserved), bits4:0 = addr.
REQ-017 CSUM SHALL equal the XOR of OPC and all data bytes; SYNC_BYTE is excluded.
REQ-018 States SHALL be HUNT, OPC, DATA, CSUM, ISSUE.
REQ-019 HUNT: a byte equal to SYNC_BYTE SHALL go to OPC; any other byte SHALL be dropped silently.
REQ-020 OPC: a byte with reserved bits nonzero SHALL pulse err_pulse[0] and go to HUNT.
REQ-021 OPC: a valid write opcode SHALL go to DATA; a valid read opcode SHALL go to CSUM.
REQ-022 DATA SHALL use a 2-bit byte counter and go to CSUM after the 4th byte.
REQ-023 CSUM: a byte matching the running XOR SHALL go to ISSUE; a mismatch SHALL pulse err_pulse[1] and go to HUNT.
REQ-024 ISSUE: cmd_valid SHALL be 1, rx_ready 0, and cmd_* SHALL stay stable until cmd_ready.
REQ-025 In ISSUE, the cycle with cmd_ready=1 SHALL return to HUNT; cmd_valid SHALL be 0 the next cycle.
REQ-026 rx_ready SHALL be 1 in every state except ISSUE.
REQ-027 Minimum latency SHALL be one cycle: cmd_valid=1 the cycle after the CSUM byte is accepted.
REQ-028 The timeout counter SHALL clear on every accepted byte and count only in OPC, DATA and CSUM.
REQ-029 Timeout: when the counter reaches TIMEOUT_CYCLES-1 without a byte, the parser SHALL pulse err_pulse[2], go to HUNT and discard partial data.
REQ-030 Timeout SHALL never fire in HUNT or ISSUE.
REQ-031 Arriving bytes SHALL be ignored in ISSUE; the upstream holds them via rx_ready=0.
REQ-032 A byte equal to SYNC_BYTE inside a frame SHALL be treated as data, not as a resync.

Reset
REQ-033 Asserting rst_n low SHALL immediately force state to HUNT and clear all registers.
REQ-034 During reset, outputs SHALL be cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_wdata=0, err_pulse=0, rx_ready=0.
REQ-035 rx_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-036 Reset asserted mid-frame or in ISSUE SHALL abandon the command without any error pulse.

Structure
REQ-037 A shared package uart_cmd_pkg SHALL hold the state enum, OPC field positions, the default SYNC_BYTE and the err_pulse bit indices.
REQ-038 One sub-module, uart_cmd_timer (clear/enable inputs, expire output), SHALL implement the timeout; all other logic SHALL be flat.

Verification
REQ-039 Write: A5 83 DE AD BE EF A1 -> cmd_valid with we=1, addr=3, wdata=32'hDEADBEEF; held across 3 cycles of cmd_ready=0.
REQ-040 Read: A5 1F 1F -> cmd_valid with we=0, addr=31, wdata=0; cmd_valid=0 the cycle after cmd_ready.
REQ-041 Bad checksum: A5 83 DE AD BE EF A0 -> err_pulse=3'b010 for one cycle, no cmd_valid; then A5 1F 1F parses correctly.
REQ-042 Bad opcode: A5 41 -> err_pulse=3'b001; noise 00 FF 12 in HUNT -> no error, no command.
REQ-043 Timeout with TIMEOUT_CYCLES=16: A5 83 DE then silence -> err_pulse=3'b100 exactly 15 cycles after DE is accepted.
REQ-044 rst_n low in the middle of the DATA bytes -> outputs zero at once, no error pulse; a full write frame afterwards is accepted.
